// File: rtl/m_sequence.sv
// m_sequence: Fibonacci LFSR m-sequence generator; taps and initial state are captured on the first edge after reset.
// Optional build macro MSEQ_ZERO_GUARD_EN replaces any all-zero state with 1 so the generator cannot lock up.
module m_sequence #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  MSEQ_clk,
    input  logic                  MSEQ_rst_n,
    input  logic [DATA_WIDTH-1:0] MSEQ_seed,
    input  logic [DATA_WIDTH-1:0] MSEQ_init_value,
    output logic                  MSEQ_output
);

    logic [DATA_WIDTH-1:0] state;
    logic [DATA_WIDTH-1:0] taps;
    logic                  loaded;

    function automatic logic [DATA_WIDTH-1:0] shift_next(
        input logic [DATA_WIDTH-1:0] s,
        input logic [DATA_WIDTH-1:0] t
    );
        return {^(s & t), s[DATA_WIDTH-1:1]};
    endfunction

    function automatic logic [DATA_WIDTH-1:0] zero_guard(input logic [DATA_WIDTH-1:0] s);
`ifdef MSEQ_ZERO_GUARD_EN
        return (s == '0) ? {{(DATA_WIDTH-1){1'b0}}, 1'b1} : s;
`else
        return s;
`endif
    endfunction

    // Load and run edges: the port values are sampled only on the load edge.
    always_ff @(posedge MSEQ_clk or negedge MSEQ_rst_n) begin
        if (!MSEQ_rst_n) begin
            state  <= '0;
            taps   <= '0;
            loaded <= 1'b0;
        end else if (!loaded) begin
            state  <= zero_guard(MSEQ_init_value);
            taps   <= MSEQ_seed;
            loaded <= 1'b1;
        end else begin
            state  <= zero_guard(shift_next(state, taps));
        end
    end

    assign MSEQ_output = state[0];

endmodule

// File: tb/tb_m_sequence.sv
// Testbench for m_sequence: directed runs with a scoreboard queue drained by a negedge monitor.
module tb_m_sequence;

    logic       clk;
    logic       rst_n;
    logic [7:0] seed;
    logic [7:0] init;
    logic       mseq_out;

    int checks = 0;
    int errors = 0;
    int ones   = 0;

    typedef struct {
        logic  exp;
        bit    chk;
        bit    cnt;
        bit    last;
        int    cnt_exp;
        string name;
    } sb_t;

    sb_t q[$];

    m_sequence #(.DATA_WIDTH(8)) dut (
        .MSEQ_clk        (clk),
        .MSEQ_rst_n      (rst_n),
        .MSEQ_seed       (seed),
        .MSEQ_init_value (init),
        .MSEQ_output     (mseq_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // Monitor: one scoreboard entry per cycle, sampled on the falling edge.
    always @(negedge clk) begin
        sb_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (e.chk) begin
                checks++;
                if (mseq_out !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %0b expected %0b", e.name, mseq_out, e.exp);
                end
            end
            if (e.cnt) begin
                if (mseq_out === 1'b1) ones++;
                if (e.last) begin
                    checks++;
                    if (ones != e.cnt_exp) begin
                        errors++;
                        $display("FAIL %s_ones: got %0d expected %0d", e.name, ones, e.cnt_exp);
                    end
                    ones = 0;
                end
            end
        end
    end

    task automatic push(input logic exp, input bit chk, input bit cnt, input bit last,
                        input int cnt_exp, input string name);
        sb_t e;
        e.exp = exp; e.chk = chk; e.cnt = cnt; e.last = last; e.cnt_exp = cnt_exp; e.name = name;
        q.push_back(e);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Reset is asserted asynchronously mid-cycle; the edge after release is the load edge.
    task automatic start_seq(input logic [7:0] s, input logic [7:0] i);
        cycle();
        rst_n = 1'b0;
        push(1'b0, 1, 0, 0, 0, "reset_async");
        cycle();
        push(1'b0, 1, 0, 0, 0, "reset_hold");
        cycle();
        seed  = s;
        init  = i;
        rst_n = 1'b1;
        push(1'b0, 1, 0, 0, 0, "preload");
    endtask

    // bits[k] is the expected output after k run edges (k=0 is right after the load edge).
    task automatic hand_run(input logic [31:0] bits, input int n, input string name);
        for (int k = 0; k < n; k++) begin
            cycle();
            push(bits[k], 1, 0, 0, 0, name);
        end
    endtask

    // First 8 outputs are the initial state LSB first; 255 edges later the same 8 bits recur.
    task automatic run_period(input logic [7:0] i, input bit scramble, input string name);
        int   idx;
        logic e;
        for (int k = 0; k < 263; k++) begin
            cycle();
            if (scramble) begin
                seed = 8'($urandom);
                init = 8'($urandom);
            end
            idx = (k >= 255) ? k - 255 : k;
            e   = (idx < 8) ? i[idx] : 1'b0;
            push(e, (k < 8) || (k >= 255), k < 255, k == 254, 128, name);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        seed  = 8'd0;
        init  = 8'd0;

        // Basic load/shift with seed 113, init 54: states 36 1B 0D 86 43 21 10 88 44.
        start_seq(8'd113, 8'd54);
        hand_run(32'h0000_0036, 9, "basic_113");
        repeat (11) cycle();

        // Reset 20 cycles into the run, restart with init 55 and seed 169.
        start_seq(8'd169, 8'd55);
        run_period(8'd55, 1'b0, "period_169");

        start_seq(8'd45, 8'd54);
        run_period(8'd54, 1'b0, "period_45");

        // Inputs scrambled every cycle after load must not disturb the sequence.
        start_seq(8'd113, 8'd54);
        run_period(8'd54, 1'b1, "freeze_113");

        start_seq(8'd113, 8'd0);
`ifdef MSEQ_ZERO_GUARD_EN
        run_period(8'd1, 1'b0, "zero_init_guard");
`else
        hand_run(32'h0000_0000, 20, "zero_init");
`endif

        start_seq(8'd0, 8'hFF);
`ifdef MSEQ_ZERO_GUARD_EN
        hand_run(32'h000F_FFFF, 20, "taps0_guard");
`else
        hand_run(32'h0000_00FF, 20, "taps0");
`endif

        cycle();
        cycle();
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/m_sequence.md
M_SEQUENCE -- requirements
Module: m_sequence

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving the LFSR length and the width of the seed and init ports; legal range 2..32.
REQ-002 SHALL have port MSEQ_clk, input, 1 bit: the clock; all state updates occur on its rising edge.
REQ-003 SHALL have port MSEQ_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port MSEQ_seed, input, DATA_WIDTH bits: feedback tap mask; bit i set means state bit i enters the feedback XOR.
REQ-005 SHALL have port MSEQ_init_value, input, DATA_WIDTH bits: initial LFSR state.
REQ-006 SHALL have port MSEQ_output, output, 1 bit: the serial m-sequence bit.

Function
REQ-007 SHALL hold internal registers: state[DATA_WIDTH-1:0], taps[DATA_WIDTH-1:0] and a 1-bit loaded flag.
REQ-008 SHALL drive MSEQ_output = state[0] directly from the register, with no combinational path from any input.
REQ-009 Load cycle: on the first rising edge with loaded=0, SHALL set state <= MSEQ_init_value, taps <= MSEQ_seed and loaded <= 1.
REQ-010 Run cycles: on each rising edge with loaded=1, SHALL compute fb = XOR-reduce(state & taps) and set state <= {fb, state[DATA_WIDTH-1:1]} (Fibonacci form, shift right, feedback into the MSB).
REQ-011 With a primitive mask, SHALL produce a sequence of period 2^DATA_WIDTH-1. For example, mask 113 (x^8+x^6+x^5+x^4+1) gives period 255.
REQ-012 SHALL ignore MSEQ_seed and MSEQ_init_value while loaded=1; a change takes effect only after the next reset.
REQ-013 Taps=0: fb is 0 and the state shifts out to all-zero; no error indication.
REQ-014 Reset asserted mid-sequence SHALL abort the sequence at once, and the next load SHALL use the port values present at that edge.

Reset
REQ-015 While MSEQ_rst_n=0, SHALL hold state=0, taps=0, loaded=0, so MSEQ_output=0 asynchronously.
REQ-016 The first rising edge after MSEQ_rst_n deasserts SHALL be the load cycle of REQ-009.
REQ-017 SHALL not load a non-constant value asynchronously; input values are captured only synchronously.

Configuration
REQ-018 With macro MSEQ_ZERO_GUARD_EN defined:
- the load cycle SHALL load state=1 when MSEQ_init_value=0;
- any run cycle whose next state would be all-zero SHALL load state=1 instead.
REQ-019 Without MSEQ_ZERO_GUARD_EN, SHALL load values verbatim, and the all-zero state SHALL persist, giving MSEQ_output constant 0.

Verification
REQ-020 Basic load and shift: DATA_WIDTH=8, seed=113, init=54, release reset -> output after the load edge is 0, then 1, 1 on the next two edges; state goes 0x36, 0x1B, 0x0D.
REQ-021 Period check: seed=113, 169 and 45 each with init=54 -> the state returns to 0x36 after exactly 255 run cycles, with 128 ones and 127 zeros per period.
REQ-022 Reset mid-run: assert reset 20 cycles into a sequence, then release with init=55 and seed=169 -> output is 0 during reset, then 1 after the load edge, and the new sequence is followed with no residue from the old one.
REQ-023 Input freeze: change seed and init every cycle after the load -> output is identical to the run with constant inputs.
REQ-024 Zero init: init=0, seed=113 -> with MSEQ_ZERO_GUARD_EN the state after the load is 0x01 and a 255-cycle period follows; without the macro the output stays 0.
